// File: rtl/two_bcd_timer.sv
// Two-digit BCD up/down timer with run/pause control, programmable terminal
// value and wrap/stop behaviour, advancing on a one-cycle tick enable.
module two_bcd_timer #(
    parameter int unsigned LIMIT_TENS = 5,
    parameter int unsigned LIMIT_ONES = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       dir,
    input  logic       wrap,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic       running,
    output logic       done
);

    localparam bit LIMIT_OK = (LIMIT_TENS <= 9) && (LIMIT_ONES <= 9) &&
                              ((LIMIT_TENS * 10 + LIMIT_ONES) >= 1);
    localparam logic [3:0] LIM_T = 4'(LIMIT_TENS);
    localparam logic [3:0] LIM_O = 4'(LIMIT_ONES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } state_t;

    state_t     state, nxt_state;
    logic [3:0] nxt_d0, nxt_d1;
    logic       nxt_done;

    logic [3:0] s_tens, s_ones, t_tens, t_ones;
    logic [3:0] adv_tens, adv_ones;
    logic       at_term, adv_term;

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (LIMIT_OK)
            else $error("two_bcd_timer: illegal LIMIT_TENS/LIMIT_ONES combination");
        end
    end

    // Start/terminal values and the one-step BCD advance for the current dir.
    always_comb begin
        s_tens = dir ? LIM_T : 4'd0;
        s_ones = dir ? LIM_O : 4'd0;
        t_tens = dir ? 4'd0 : LIM_T;
        t_ones = dir ? 4'd0 : LIM_O;
        at_term = (digit1 == t_tens) && (digit0 == t_ones);
        if (!dir) begin
            if (digit0 == 4'd9) begin
                adv_ones = 4'd0;
                adv_tens = digit1 + 4'd1;
            end else begin
                adv_ones = digit0 + 4'd1;
                adv_tens = digit1;
            end
        end else begin
            if (digit0 == 4'd0) begin
                adv_ones = 4'd9;
                adv_tens = digit1 - 4'd1;
            end else begin
                adv_ones = digit0 - 4'd1;
                adv_tens = digit1;
            end
        end
        adv_term = (adv_tens == t_tens) && (adv_ones == t_ones);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            digit0 <= '0;
            digit1 <= '0;
            done   <= 1'b0;
        end else begin
            state  <= nxt_state;
            digit0 <= nxt_d0;
            digit1 <= nxt_d1;
            done   <= nxt_done;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_d0    = digit0;
        nxt_d1    = digit1;
        nxt_done  = 1'b0;
        if (clear) begin
            nxt_state = ST_IDLE;
            nxt_d0    = '0;
            nxt_d1    = '0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_stop) begin
                        nxt_state = ST_RUN;
                        nxt_d1    = s_tens;
                        nxt_d0    = s_ones;
                    end
                end
                ST_RUN: begin
                    // A tick coinciding with start_stop is applied before pausing.
                    if (tick) begin
                        if (at_term) begin
                            if (wrap) begin
                                nxt_d1   = s_tens;
                                nxt_d0   = s_ones;
                                nxt_done = 1'b1;
                            end else begin
                                nxt_state = ST_DONE;
                            end
                        end else begin
                            nxt_d1 = adv_tens;
                            nxt_d0 = adv_ones;
                            if (!wrap && adv_term) begin
                                nxt_state = ST_DONE;
                                nxt_done  = 1'b1;
                            end
                        end
                    end
                    if (start_stop) begin
                        nxt_state = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (start_stop) begin
                        nxt_state = ST_RUN;
                    end
                end
                default: nxt_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        running = (state == ST_RUN);
    end

endmodule

// File: tb/tb_two_bcd_timer.sv
// Directed bench for two_bcd_timer: integer-valued reference model checked
// every cycle for a default and a 23-limit instance, plus literal checkpoints.
module tb_two_bcd_timer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0, start_stop = 1'b0, clear = 1'b0, dir = 1'b0, wrap = 1'b0;
    logic [3:0] a_d0, a_d1, b_d0, b_d1;
    logic a_run, a_done, b_run, b_done;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    two_bcd_timer u_a (
        .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .clear(clear),
        .dir(dir), .wrap(wrap), .digit0(a_d0), .digit1(a_d1), .running(a_run), .done(a_done)
    );

    two_bcd_timer #(.LIMIT_TENS(2), .LIMIT_ONES(3)) u_b (
        .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .clear(clear),
        .dir(dir), .wrap(wrap), .digit0(b_d0), .digit1(b_d1), .running(b_run), .done(b_done)
    );

    // Reference model: value as a plain integer, mode 0 idle / 1 run / 2 pause / 3 finished.
    typedef struct {
        int val;
        int mode;
        bit dn;
    } model_t;

    model_t ma = '{0, 0, 1'b0};
    model_t mb = '{0, 0, 1'b0};

    function automatic model_t step_model(model_t m, int lim, bit r, bit c, bit s, bit t, bit d, bit w);
        model_t n = m;
        int sv = d ? lim : 0;
        int tv = d ? 0 : lim;
        n.dn = 1'b0;
        if (r || c) begin
            n.val  = 0;
            n.mode = 0;
            return n;
        end
        case (m.mode)
            0, 3: if (s) begin n.mode = 1; n.val = sv; end
            1: begin
                if (t) begin
                    if (m.val == tv) begin
                        if (w) begin n.val = sv; n.dn = 1'b1; end
                        else n.mode = 3;
                    end else begin
                        n.val = m.val + (d ? -1 : 1);
                        if (!w && n.val == tv) begin n.mode = 3; n.dn = 1'b1; end
                    end
                end
                if (s) n.mode = 2;
            end
            2: if (s) n.mode = 1;
            default: n.mode = 0;
        endcase
        return n;
    endfunction

    always @(posedge clk) begin
        ma <= step_model(ma, 59, rst, clear, start_stop, tick, dir, wrap);
        mb <= step_model(mb, 23, rst, clear, start_stop, tick, dir, wrap);
    end

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            check("a_value",   int'(a_d1) * 10 + int'(a_d0), ma.val);
            check("a_ones",    int'(a_d0), ma.val % 10);
            check("a_running", int'(a_run), int'(ma.mode == 1));
            check("a_done",    int'(a_done), int'(ma.dn));
            check("b_value",   int'(b_d1) * 10 + int'(b_d0), mb.val);
            check("b_running", int'(b_run), int'(mb.mode == 1));
            check("b_done",    int'(b_done), int'(mb.dn));
        end
    end

    task automatic cyc(input bit s, input bit c, input bit t);
        start_stop = s;
        clear      = c;
        tick       = t;
        @(posedge clk);
        #1;
        start_stop = 1'b0;
        clear      = 1'b0;
        tick       = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b1);
    endtask

    task automatic expect_a(input string name, input int val, input bit run, input bit dn);
        check({name, "_val"}, int'(a_d1) * 10 + int'(a_d0), val);
        check({name, "_run"}, int'(a_run), int'(run));
        check({name, "_done"}, int'(a_done), int'(dn));
    endtask

    initial begin
        rst = 1'b1;
        cyc(0, 0, 0);
        checking = 1'b1;
        cyc(0, 0, 1);
        rst = 1'b0;
        expect_a("reset", 0, 0, 0);

        // Up, stop at terminal
        dir = 1'b0; wrap = 1'b0;
        cyc(1, 0, 0);
        expect_a("up_start", 0, 1, 0);
        ticks(59);
        expect_a("up_term", 59, 0, 1);
        cyc(0, 0, 0);
        expect_a("up_done_once", 59, 0, 0);
        ticks(3);
        expect_a("up_hold", 59, 0, 0);
        cyc(1, 0, 0);
        expect_a("up_restart", 0, 1, 0);

        // Reset mid-count
        ticks(37);
        expect_a("at37", 37, 1, 0);
        rst = 1'b1;
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        rst = 1'b0;
        expect_a("mid_reset", 0, 0, 0);

        // Up with wrap
        wrap = 1'b1;
        cyc(1, 0, 0);
        ticks(8);
        expect_a("wrap08", 8, 1, 0);
        ticks(2);
        expect_a("carry10", 10, 1, 0);
        ticks(49);
        expect_a("wrap59", 59, 1, 0);
        ticks(1);
        expect_a("wrap_to00", 0, 1, 1);
        cyc(0, 0, 0);
        expect_a("wrap_done_clr", 0, 1, 0);

        // Down with wrap, then stop at 00
        cyc(0, 1, 0);
        dir = 1'b1;
        cyc(1, 0, 0);
        expect_a("down_load", 59, 1, 0);
        ticks(9);
        expect_a("down50", 50, 1, 0);
        ticks(1);
        expect_a("borrow49", 49, 1, 0);
        ticks(49);
        expect_a("down00", 0, 1, 0);
        ticks(1);
        expect_a("down_wrap", 59, 1, 1);
        wrap = 1'b0;
        ticks(59);
        expect_a("down_stop", 0, 0, 1);

        // Pause / resume
        cyc(0, 1, 0);
        dir = 1'b0;
        cyc(1, 0, 0);
        ticks(23);
        expect_a("at23", 23, 1, 0);
        cyc(1, 0, 1);
        expect_a("pause24", 24, 0, 0);
        ticks(5);
        expect_a("paused_hold", 24, 0, 0);
        cyc(1, 0, 0);
        expect_a("resume", 24, 1, 0);
        ticks(1);
        expect_a("resume25", 25, 1, 0);
        cyc(1, 0, 1);
        cyc(1, 0, 1);
        expect_a("pause_tick_ignored", 26, 1, 0);

        // Mid-run direction change takes effect without reload
        dir = 1'b1;
        ticks(2);
        expect_a("dir_flip", 24, 1, 0);
        dir = 1'b0;

        // Clear priority over start_stop and tick
        cyc(0, 1, 0);
        cyc(1, 0, 0);
        ticks(42);
        expect_a("at42", 42, 1, 0);
        cyc(1, 1, 1);
        expect_a("clear_prio", 0, 0, 0);
        ticks(2);
        expect_a("idle_ignores_tick", 0, 0, 0);

        // Limit 23 instance: count to terminal and wrap
        wrap = 1'b1;
        cyc(1, 0, 0);
        ticks(23);
        check("b_at23", int'(b_d1) * 10 + int'(b_d0), 23);
        ticks(1);
        check("b_wrap_val", int'(b_d1) * 10 + int'(b_d0), 0);
        check("b_wrap_done", int'(b_done), 1);
        check("b_wrap_run", int'(b_run), 1);
        cyc(0, 0, 0);

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
